// File: rtl/fmap_load_ctrl.sv
// fmap_load_ctrl: reads ceil(m*n*BITS/32) words from base_addr and streams them to the packer.
// Latency: pk_en/pk_data follow mem_rvalid/mem_rdata by exactly one cycle.
// Backpressure: at most MAX_OUTS reads in flight; mem_addr holds while a request waits for mem_gnt.
module fmap_load_ctrl #(
  parameter int BITS     = 8,   // pixel width; 32/BITS pixels per memory word
  parameter int DIM      = 32,  // largest legal m or n
  parameter int ADDR_W   = 16,  // word-address width
  parameter int MAX_OUTS = 4,   // read requests allowed in flight
  localparam int D       = $clog2(DIM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [D-1:0]      m,
  input  logic [D-1:0]      n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              pk_rst_n,
  output logic              pk_en,
  output logic [31:0]       pk_data,
  output logic [D-1:0]      pk_m,
  output logic [D-1:0]      pk_n,
  input  logic              pk_full
);

  // Word counters live in a 10-bit field; 32x32 8-bit pixels need 256 words.
  localparam int              CW         = 10;
  localparam int              PPW_LOG    = $clog2(32 / BITS);
  localparam int              PW         = 2 * D + 1;
  localparam logic [D-1:0]    DIM_D      = D'(DIM);
  localparam logic [CW-1:0]   MAX_OUTS_C = CW'(MAX_OUTS);
  localparam logic [PW-1:0]   ROUND_UP   = PW'((1 << PPW_LOG) - 1);
  localparam logic [CW-1:0]   ONE        = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [D-1:0]        m_q, m_d;
  logic [D-1:0]        n_q, n_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CW-1:0]       w_q, w_d;
  logic                bad_q, bad_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [CW-1:0]       received_q, received_d;
  logic                err_q, err_d;
  logic                pk_en_q, pk_en_d;
  logic [31:0]         pk_data_q, pk_data_d;
  logic                rst_hold_q, rst_hold_d;

  logic [PW-1:0]       prod;
  logic [PW-1:0]       prod_rnd;
  logic [CW-1:0]       w_calc;
  logic                bad_calc;
  logic [CW-1:0]       outs;
  logic                grant;

  // Word count and dimension legality for the map being requested.
  always_comb begin
    prod     = PW'(m) * PW'(n);
    prod_rnd = prod + ROUND_UP;
    w_calc   = CW'(prod_rnd >> PPW_LOG);
    bad_calc = (m == '0) || (n == '0) || (m > DIM_D) || (n > DIM_D);
  end

  assign outs  = issued_q - received_q;
  assign grant = mem_req && mem_gnt;

  // Request is dropped combinationally on abort so no grant can land in that cycle.
  assign mem_req  = (state_q == ST_FETCH) && !abort &&
                    (issued_q < w_q) && (outs < MAX_OUTS_C);
  assign mem_addr = base_q + ADDR_W'(issued_q);

  assign busy     = (state_q != ST_IDLE);
  // Done fires once the final packer write has been seen, i.e. pk_full is now meaningful.
  assign done     = (state_q == ST_FINISH) && !pk_en_q;
  assign err      = err_q;
  assign pk_en    = pk_en_q;
  assign pk_data  = pk_data_q;
  assign pk_m     = m_q;
  assign pk_n     = n_q;
  // Packer is held in clear during reset, one cycle after it, and in CLEAR for a legal map.
  assign pk_rst_n = !(rst_hold_q || ((state_q == ST_CLEAR) && !bad_q));

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    base_d     = base_q;
    w_d        = w_q;
    bad_d      = bad_q;
    issued_d   = issued_q;
    received_d = received_q;
    err_d      = err_q;
    pk_en_d    = 1'b0;
    pk_data_d  = pk_data_q;
    rst_hold_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d        = m;
          n_d        = n;
          base_d     = base_addr;
          w_d        = w_calc;
          bad_d      = bad_calc;
          err_d      = bad_calc;
          issued_d   = '0;
          received_d = '0;
          state_d    = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        // An illegal map spends its single busy cycle here and never touches memory.
        if (bad_q) begin
          state_d = ST_IDLE;
        end else if (abort) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (grant) begin
          issued_d = issued_q + ONE;
        end
        if (mem_rvalid) begin
          if (received_q < w_q) begin
            pk_en_d    = 1'b1;
            pk_data_d  = mem_rdata;
            received_d = received_q + ONE;
          end else begin
            err_d = 1'b1;
          end
        end
        if (abort) begin
          state_d = ST_DRAIN;
        end else if (received_d == w_q) begin
          state_d = ST_FINISH;
        end
      end

      ST_DRAIN: begin
        // Responses still owed by memory are counted off and thrown away.
        if (mem_rvalid && (outs != '0)) begin
          received_d = received_q + ONE;
        end
        if (issued_q == received_d) begin
          state_d = ST_IDLE;
        end
      end

      ST_FINISH: begin
        if (!pk_en_q) begin
          err_d   = err_q || !pk_full;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched job parameters, counters and packer output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      n_q        <= '0;
      base_q     <= '0;
      w_q        <= '0;
      bad_q      <= 1'b0;
      issued_q   <= '0;
      received_q <= '0;
      err_q      <= 1'b0;
      pk_en_q    <= 1'b0;
      pk_data_q  <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      n_q        <= n_d;
      base_q     <= base_d;
      w_q        <= w_d;
      bad_q      <= bad_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      err_q      <= err_d;
      pk_en_q    <= pk_en_d;
      pk_data_q  <= pk_data_d;
      rst_hold_q <= rst_hold_d;
    end
  end

endmodule

// File: tb/tb_fmap_load_ctrl.sv
// tb_fmap_load_ctrl: directed loads against a behavioural memory with selectable latency/stalls.
// Latency: memory answers each grant a programmable number of cycles later, in order.
// Backpressure: optional mode withholds mem_gnt for two cycles per request.
module tb_fmap_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [5:0]  m;
  logic [5:0]  n;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        pk_rst_n;
  logic        pk_en;
  logic [31:0] pk_data;
  logic [5:0]  pk_m;
  logic [5:0]  pk_n;
  logic        pk_full;

  fmap_load_ctrl #(
    .BITS(8), .DIM(32), .ADDR_W(16), .MAX_OUTS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .m(m), .n(n), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pk_rst_n(pk_rst_n), .pk_en(pk_en), .pk_data(pk_data),
    .pk_m(pk_m), .pk_n(pk_n), .pk_full(pk_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model and monitor state.
  int          cyc = 0;
  int          lat = 1;
  bit          stall_mode = 0;
  int          stall_cnt = 0;
  logic [15:0] rq_addr[$];
  int          rq_due[$];
  bit          inject_rv = 0;
  bit          injected = 0;
  bit          fwd_ok = 0;
  bit          exp_pken = 0;
  bit          prev_stalled = 0;
  logic [15:0] prev_addr = '0;
  logic [15:0] exp_base = '0;
  logic [15:0] ea;
  logic [15:0] addr_at2 = '0;
  logic [15:0] last_addr = '0;
  int n_grant = 0, n_req = 0, n_busy = 0, n_done = 0, n_clr = 0, n_pken = 0;
  int addr_bad = 0, data_bad = 0, lat_bad = 0, stable_bad = 0, outs = 0, max_outs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [15:0] a);
    mk_data = {a ^ 16'h5A5A, a};
  endfunction

  task automatic clr_stats();
    n_grant = 0; n_req = 0; n_busy = 0; n_done = 0; n_clr = 0; n_pken = 0;
    addr_bad = 0; data_bad = 0; lat_bad = 0; stable_bad = 0; outs = 0; max_outs = 0;
    stall_cnt = 0; prev_stalled = 0; exp_pken = 0;
  endtask

  // Drives inputs on the falling edge, samples DUT three time units later.
  initial begin : responder
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt = stall_mode ? (stall_cnt >= 2) : 1'b1;
      injected = 0;
      if (inject_rv) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; inject_rv = 0; injected = 1;
      end else if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
        mem_rvalid = 1'b1; mem_rdata = mk_data(rq_addr.pop_front()); void'(rq_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
      end
      #3;
      if (mem_req && mem_gnt) begin
        ea = exp_base + 16'(n_grant);
        if (mem_addr !== ea) addr_bad++;
        if (n_grant == 2) addr_at2 = mem_addr;
        last_addr = mem_addr;
        n_grant++;
        rq_addr.push_back(mem_addr);
        rq_due.push_back(cyc + lat);
        stall_cnt = 0;
        outs++;
      end else if (mem_req) begin
        stall_cnt++;
      end
      if (prev_stalled && mem_req && mem_addr !== prev_addr) stable_bad++;
      prev_stalled = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      if (mem_rvalid && !injected && outs > 0) outs--;
      if (outs > max_outs) max_outs = outs;
      if (mem_req) n_req++;
      if (busy) n_busy++;
      if (done) n_done++;
      if (!pk_rst_n) n_clr++;
      if (!rst && pk_en !== exp_pken) lat_bad++;
      exp_pken = mem_rvalid && fwd_ok && !rst;
      if (pk_en) begin
        if (pk_data !== mk_data(exp_base + 16'(n_pken))) data_bad++;
        n_pken++;
      end
    end
  end

  task automatic do_start(input logic [5:0] mm, input logic [5:0] nn, input logic [15:0] bb);
    @(negedge clk);
    clr_stats();
    exp_base = bb; fwd_ok = 1;
    m = mm; n = nn; base_addr = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk); #4; k++;
    end while (busy === 1'b1 && k < lim);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_grants(input int want, input int lim);
    int k;
    k = 0;
    #4;
    while (n_grant < want && k < lim) begin
      @(negedge clk); #4; k++;
    end
    chk("grants_before_event", 32'(n_grant), 32'(want));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; m = '0; n = '0; pk_full = 1'b1;

    // Reset values
    @(negedge clk); #4;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_pk_en", 32'(pk_en), 32'd0);
    chk("rst_pk_data", pk_data, 32'd0);
    chk("rst_pk_m", 32'(pk_m), 32'd0);
    chk("rst_pk_n", 32'(pk_n), 32'd0);
    chk("rst_pk_rst_n", 32'(pk_rst_n), 32'd0);
    @(negedge clk); rst = 1'b0; #4;
    chk("pk_rst_n_release_cycle", 32'(pk_rst_n), 32'd0);
    @(negedge clk); #4;
    chk("pk_rst_n_after_release", 32'(pk_rst_n), 32'd1);

    // 4x4 map, always granted, 1-cycle reads
    lat = 1; stall_mode = 0; pk_full = 1'b1;
    do_start(6'd4, 6'd4, 16'h0100);
    wait_idle(100, "idle_4x4");
    chk("4x4_clear_cycles", 32'(n_clr), 32'd1);
    chk("4x4_grants", 32'(n_grant), 32'd4);
    chk("4x4_req_cycles", 32'(n_req), 32'd4);
    chk("4x4_addr_bad", 32'(addr_bad), 32'd0);
    chk("4x4_last_addr", 32'(last_addr), 32'h0103);
    chk("4x4_pk_en", 32'(n_pken), 32'd4);
    chk("4x4_data_bad", 32'(data_bad), 32'd0);
    chk("4x4_latency", 32'(lat_bad), 32'd0);
    chk("4x4_done", 32'(n_done), 32'd1);
    chk("4x4_err", 32'(err), 32'd0);
    chk("4x4_busy_cycles", 32'(n_busy), 32'd8);
    chk("4x4_pk_m", 32'(pk_m), 32'd4);
    chk("4x4_pk_n", 32'(pk_n), 32'd4);

    // m = 0 is rejected
    do_start(6'd0, 6'd4, 16'h0400);
    wait_idle(20, "idle_m0");
    chk("m0_err", 32'(err), 32'd1);
    chk("m0_busy_cycles", 32'(n_busy), 32'd1);
    chk("m0_req_cycles", 32'(n_req), 32'd0);
    chk("m0_done", 32'(n_done), 32'd0);
    chk("m0_clear_cycles", 32'(n_clr), 32'd0);

    // 3x3 map, two stall cycles per request, packer not full; second start while busy
    stall_mode = 1; pk_full = 1'b0;
    do_start(6'd3, 6'd3, 16'h0A00);
    m = 6'd7; n = 6'd7; base_addr = 16'h0B00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200, "idle_3x3");
    chk("3x3_grants", 32'(n_grant), 32'd3);
    chk("3x3_req_cycles", 32'(n_req), 32'd9);
    chk("3x3_addr_stable", 32'(stable_bad), 32'd0);
    chk("3x3_addr_bad", 32'(addr_bad), 32'd0);
    chk("3x3_last_addr", 32'(last_addr), 32'h0A02);
    chk("3x3_outs_le_4", 32'(max_outs <= 4), 32'd1);
    chk("3x3_pk_en", 32'(n_pken), 32'd3);
    chk("3x3_data_bad", 32'(data_bad), 32'd0);
    chk("3x3_latency", 32'(lat_bad), 32'd0);
    chk("3x3_done", 32'(n_done), 32'd1);
    chk("3x3_err_not_full", 32'(err), 32'd1);
    chk("3x3_pk_m", 32'(pk_m), 32'd3);
    chk("3x3_pk_n", 32'(pk_n), 32'd3);

    // 32x32 map from 0xFFFE, 5-cycle reads so the outstanding limit engages
    stall_mode = 0; pk_full = 1'b1; lat = 5;
    do_start(6'd32, 6'd32, 16'hFFFE);
    wait_idle(3000, "idle_32x32");
    chk("32x32_grants", 32'(n_grant), 32'd256);
    chk("32x32_addr_bad", 32'(addr_bad), 32'd0);
    chk("32x32_wrap_addr", 32'(addr_at2), 32'h0000);
    chk("32x32_last_addr", 32'(last_addr), 32'h00FD);
    chk("32x32_pk_en", 32'(n_pken), 32'd256);
    chk("32x32_data_bad", 32'(data_bad), 32'd0);
    chk("32x32_latency", 32'(lat_bad), 32'd0);
    chk("32x32_max_outs", 32'(max_outs), 32'd4);
    chk("32x32_done", 32'(n_done), 32'd1);
    chk("32x32_err", 32'(err), 32'd0);

    // m = 33 exceeds DIM
    do_start(6'd33, 6'd4, 16'h0500);
    wait_idle(20, "idle_m33");
    chk("m33_err", 32'(err), 32'd1);
    chk("m33_busy_cycles", 32'(n_busy), 32'd1);
    chk("m33_req_cycles", 32'(n_req), 32'd0);
    chk("m33_done", 32'(n_done), 32'd0);
    chk("m33_pk_m", 32'(pk_m), 32'd33);

    // Abort after two grants of W=16 with both responses still pending
    lat = 3;
    do_start(6'd8, 6'd8, 16'h0200);
    wait_grants(2, 50);
    @(negedge clk);
    abort = 1'b1; fwd_ok = 0;
    #4;
    chk("abort_req_same_cycle", 32'(mem_req), 32'd0);
    chk("abort_pending", 32'(rq_addr.size()), 32'd2);
    @(negedge clk);
    abort = 1'b0;
    #4;
    chk("abort_req_next_cycle", 32'(mem_req), 32'd0);
    chk("abort_draining_busy", 32'(busy), 32'd1);
    wait_idle(50, "idle_abort");
    chk("abort_grants", 32'(n_grant), 32'd2);
    chk("abort_pk_en", 32'(n_pken), 32'd0);
    chk("abort_done", 32'(n_done), 32'd0);
    chk("abort_drained", 32'(rq_addr.size()), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_latency", 32'(lat_bad), 32'd0);

    // Reset in the middle of FETCH, stray responses afterwards, then a clean load
    do_start(6'd8, 6'd8, 16'h0300);
    wait_grants(3, 50);
    @(negedge clk);
    rst = 1'b1; fwd_ok = 0;
    #4;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_pk_en", 32'(pk_en), 32'd0);
    chk("midrst_pk_data", pk_data, 32'd0);
    chk("midrst_pk_m", 32'(pk_m), 32'd0);
    chk("midrst_pk_n", 32'(pk_n), 32'd0);
    chk("midrst_pk_rst_n", 32'(pk_rst_n), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; n_pken = 0; inject_rv = 1;
    repeat (8) @(negedge clk);
    #4;
    chk("midrst_stray_pk_en", 32'(n_pken), 32'd0);
    chk("midrst_stray_drained", 32'(rq_addr.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_no_done", 32'(n_done), 32'd0);
    lat = 1;
    do_start(6'd4, 6'd4, 16'h0010);
    wait_idle(100, "idle_after_rst");
    chk("after_rst_grants", 32'(n_grant), 32'd4);
    chk("after_rst_addr_bad", 32'(addr_bad), 32'd0);
    chk("after_rst_pk_en", 32'(n_pken), 32'd4);
    chk("after_rst_data_bad", 32'(data_bad), 32'd0);
    chk("after_rst_done", 32'(n_done), 32'd1);
    chk("after_rst_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
